dm_responder: RTL and testbench

- Responder end of the M-stage data-memory interface.
- The pipeline's memory stage is the initiator: it issues load/store requests with byte enables.
- This block accepts one request at a time and applies a fixed number of wait states.
- It performs the byte-merged write or the word read, then returns a one-cycle response with data or an error flag.
- It replaces the zero-latency DM, so a later stall-on-busy pipeline can run against realistic memory timing.

---
 rtl/dm_pkg.sv | 33 +++
 rtl/dm_responder_if.sv | 31 +++
 rtl/dm_word_ram.sv | 25 ++
 rtl/dm_responder.sv | 137 +++++++++++++
 tb/tb_dm_responder.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory responder.
package dm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dm_state_e;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_BYTE1   = 4'b0010;
    localparam logic [3:0] BE_BYTE2   = 4'b0100;
    localparam logic [3:0] BE_BYTE3   = 4'b1000;

    function automatic logic [1:0] lowest_set_bit(input logic [3:0] be);
        if (be[0])      return 2'd0;
        else if (be[1]) return 2'd1;
        else if (be[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    function automatic logic be_legal(input logic [3:0] be);
        case (be)
            BE_WORD, BE_HALF_LO, BE_HALF_HI,
            BE_BYTE0, BE_BYTE1, BE_BYTE2, BE_BYTE3: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dm_responder_if.sv
// Request/response bus between the M-stage initiator and the data-memory responder.
interface dm_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    // Committed-write trace: pc, word-aligned byte address and merged word
    logic        log_valid;
    logic [31:0] log_pc;
    logic [31:0] log_addr;
    logic [31:0] log_word;

    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata, req_pc,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
               log_valid, log_pc, log_addr, log_word
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata, req_pc,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
               log_valid, log_pc, log_addr, log_word
    );
endinterface

// File: rtl/dm_word_ram.sv
// DEPTH x 32 word store with per-lane write enables, async clear and combinational read.
module dm_word_ram #(
    parameter int unsigned DEPTH = 4096,
    localparam int unsigned IW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    lane_we,
    input  logic [IW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int unsigned l = 0; l < 4; l++)
                if (lane_we[l]) mem[idx][8*l +: 8] <= wdata[8*l +: 8];
        end
    end

    assign rdata = mem[idx];
endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: one request at a time, fixed wait states, one-cycle response pulse.
module dm_responder
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH       = 4096,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned LOG_WRITES  = 1
) (
    input  logic          clk,
    input  logic          reset,
    dm_responder_if.slave bus
);
    localparam int unsigned IW    = $clog2(DEPTH);
    localparam int unsigned CW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [32:0] LIMIT = 33'(DEPTH) * 33'd4;

    dm_state_e   state, state_next;
    logic [CW-1:0] count, count_next;
    logic        accept, enter_resp, legal;
    logic        lat_we, cur_we;
    logic [31:0] lat_addr, lat_wdata, lat_pc, cur_addr, cur_wdata, cur_pc;
    logic [3:0]  lat_be, cur_be, lane_we;
    logic [31:0] ram_rdata, merged, rsp_rdata_q;
    logic        rsp_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state)
            IDLE: if (bus.req_valid) begin
                accept     = 1'b1;
                count_next = CW'(WAIT_CYCLES);
                if (WAIT_CYCLES == 0) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                count_next = count - CW'(1);
                if (count == CW'(1)) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_be    <= '0;
            lat_wdata <= '0;
            lat_pc    <= '0;
        end else if (accept) begin
            lat_we    <= bus.req_we;
            lat_addr  <= bus.req_addr;
            lat_be    <= bus.req_be;
            lat_wdata <= bus.req_wdata;
            lat_pc    <= bus.req_pc;
        end
    end

    // With zero wait states the accept edge is also the access edge, so the
    // live request stands in for the not-yet-latched copy while in IDLE.
    always_comb begin
        cur_we    = lat_we;
        cur_addr  = lat_addr;
        cur_be    = lat_be;
        cur_wdata = lat_wdata;
        cur_pc    = lat_pc;
        if (state == IDLE) begin
            cur_we    = bus.req_we;
            cur_addr  = bus.req_addr;
            cur_be    = bus.req_be;
            cur_wdata = bus.req_wdata;
            cur_pc    = bus.req_pc;
        end
    end

    assign legal = be_legal(cur_be)
                && (cur_addr[1:0] == lowest_set_bit(cur_be))
                && ({1'b0, cur_addr} < LIMIT);

    dm_word_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .reset   (reset),
        .lane_we (lane_we),
        .idx     (cur_addr[IW+1:2]),
        .wdata   (cur_wdata),
        .rdata   (ram_rdata)
    );

    always_comb begin
        merged = ram_rdata;
        for (int unsigned l = 0; l < 4; l++)
            if (cur_be[l]) merged[8*l +: 8] = cur_wdata[8*l +: 8];
    end

    assign lane_we = (enter_resp && legal && cur_we) ? cur_be : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else if (enter_resp) begin
            rsp_err_q   <= !legal;
            rsp_rdata_q <= (legal && !cur_we) ? ram_rdata : '0;
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.log_valid = (LOG_WRITES != 0) && (lane_we != 4'b0000);
    assign bus.log_pc    = cur_pc;
    assign bus.log_addr  = {cur_addr[31:2], 2'b00};
    assign bus.log_word  = merged;
endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: WAIT_CYCLES=2 instance (bus0) and WAIT_CYCLES=0 instance (bus1).
module tb_dm_responder;
    logic clk = 1'b0;
    logic rst0 = 1'b0;
    logic rst1 = 1'b0;
    always #5 clk = ~clk;

    dm_responder_if bus0 ();
    dm_responder_if bus1 ();

    dm_responder #(.DEPTH(4096), .WAIT_CYCLES(2), .LOG_WRITES(1)) dut0 (
        .clk(clk), .reset(rst0), .bus(bus0));
    dm_responder #(.DEPTH(4096), .WAIT_CYCLES(0), .LOG_WRITES(0)) dut1 (
        .clk(clk), .reset(rst1), .bus(bus1));

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        bit          logged;
        logic [31:0] addr;
        logic [31:0] word;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] logq[$];
    logic [31:0] model0[int];
    logic [31:0] model1[int];
    int          pass_cnt = 0;
    int          total_cnt = 0;

    always @(posedge clk) begin
        if (bus0.log_valid) begin
            $display("@%h: *%h <= %h", bus0.log_pc, bus0.log_addr, bus0.log_word);
            logq.push_back({bus0.log_addr, bus0.log_word});
        end
        if (bus1.log_valid) logq.push_back({bus1.log_addr, bus1.log_word});
    end

    function automatic logic rv(int d);  return d == 0 ? bus0.rsp_valid : bus1.rsp_valid; endfunction
    function automatic logic rdy(int d); return d == 0 ? bus0.req_ready : bus1.req_ready; endfunction
    function automatic logic bsy(int d); return d == 0 ? bus0.busy : bus1.busy; endfunction
    function automatic logic rer(int d); return d == 0 ? bus0.rsp_err : bus1.rsp_err; endfunction
    function automatic logic [31:0] rdt(int d); return d == 0 ? bus0.rsp_rdata : bus1.rsp_rdata; endfunction

    function automatic logic [31:0] m_read(int d, int idx);
        if (d == 0) return model0.exists(idx) ? model0[idx] : 32'h0;
        return model1.exists(idx) ? model1[idx] : 32'h0;
    endfunction

    function automatic bit legal_m(logic [31:0] addr, logic [3:0] be);
        bit ok;
        case (be)
            4'b1111, 4'b0011, 4'b0001: ok = (addr[1:0] == 2'd0);
            4'b0010:                   ok = (addr[1:0] == 2'd1);
            4'b1100, 4'b0100:          ok = (addr[1:0] == 2'd2);
            4'b1000:                   ok = (addr[1:0] == 2'd3);
            default:                   ok = 1'b0;
        endcase
        return ok && (addr < 32'h4000);
    endfunction

    task automatic drive(int d, logic v, logic we, logic [31:0] addr, logic [3:0] be, logic [31:0] wdata);
        if (d == 0) begin
            bus0.req_valid = v; bus0.req_we = we; bus0.req_addr = addr;
            bus0.req_be = be; bus0.req_wdata = wdata; bus0.req_pc = 32'h0040_0000 + addr;
        end else begin
            bus1.req_valid = v; bus1.req_we = we; bus1.req_addr = addr;
            bus1.req_be = be; bus1.req_wdata = wdata; bus1.req_pc = 32'h0040_0000 + addr;
        end
    endtask

    function automatic exp_t predict(int d, logic we, logic [31:0] addr, logic [3:0] be, logic [31:0] wdata);
        exp_t e;
        bit ok = legal_m(addr, be);
        logic [31:0] old = m_read(d, int'(addr[31:2]));
        logic [31:0] mw = old;
        for (int l = 0; l < 4; l++) if (be[l]) mw[8*l +: 8] = wdata[8*l +: 8];
        e.err    = !ok;
        e.rdata  = (ok && !we) ? old : 32'h0;
        e.logged = ok && we && (d == 0);
        e.addr   = {addr[31:2], 2'b00};
        e.word   = mw;
        if (ok && we) begin
            if (d == 0) model0[int'(addr[31:2])] = mw;
            else        model1[int'(addr[31:2])] = mw;
        end
        return e;
    endfunction

    task automatic check_rsp(string name, int d);
        exp_t e = sb.pop_front();
        total_cnt++;
        if (rdt(d) !== e.rdata) $display("FAIL %s rdata got %h want %h", name, rdt(d), e.rdata);
        else pass_cnt++;
        total_cnt++;
        if (rer(d) !== e.err) $display("FAIL %s err got %b want %b", name, rer(d), e.err);
        else pass_cnt++;
        total_cnt++;
        if (e.logged) begin
            if (logq.size() == 0) $display("FAIL %s log got none want %h<=%h", name, e.addr, e.word);
            else begin
                logic [63:0] lg = logq.pop_front();
                if (lg !== {e.addr, e.word}) $display("FAIL %s log got %h want %h", name, lg, {e.addr, e.word});
                else pass_cnt++;
            end
        end else begin
            if (logq.size() != 0) $display("FAIL %s log got %0d entries want 0", name, logq.size());
            else pass_cnt++;
            logq.delete();
        end
    endtask

    task automatic xact(int d, logic we, logic [31:0] addr, logic [3:0] be, logic [31:0] wdata,
                        string name, bit inject);
        int wc = (d == 0) ? 2 : 0;
        int k = 0;
        sb.push_back(predict(d, we, addr, be, wdata));
        @(negedge clk);
        drive(d, 1'b1, we, addr, be, wdata);
        @(posedge clk);
        #1 drive(d, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        for (int i = 1; i <= 20 && k == 0; i++) begin
            @(negedge clk);
            if (inject && i == 1) drive(d, 1'b1, 1'b1, 32'h60, 4'hf, 32'h9999_9999);
            if (inject && i == 2) drive(d, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            if (rv(d)) k = i;
        end
        total_cnt++;
        if (k != wc + 1) $display("FAIL %s latency got %0d want %0d", name, k, wc + 1);
        else pass_cnt++;
        check_rsp(name, d);
        @(negedge clk);
        total_cnt++;
        if (rv(d) !== 1'b0 || rdy(d) !== 1'b1)
            $display("FAIL %s after_rsp valid/ready got %b%b want 01", name, rv(d), rdy(d));
        else pass_cnt++;
    endtask

    task automatic test_reset();
        drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total_cnt++;
            if ({rdy(d), rv(d), rer(d), bsy(d)} !== 4'b1000 || rdt(d) !== 32'h0)
                $display("FAIL reset_state dut%0d got rdy/v/err/busy %b%b%b%b rdata %h want 1000 00000000",
                         d, rdy(d), rv(d), rer(d), bsy(d), rdt(d));
            else pass_cnt++;
        end
        rst0 = 1'b1;
        rst1 = 1'b1;
    endtask

    task automatic test_word();
        xact(0, 1'b1, 32'h10, 4'hf, 32'h1234_5678, "word_store", 1'b0);
        xact(0, 1'b0, 32'h10, 4'hf, 32'h0, "word_load", 1'b0);
    endtask

    task automatic test_byte_merge();
        xact(0, 1'b1, 32'h20, 4'hf, 32'hAABB_CCDD, "merge_base", 1'b0);
        xact(0, 1'b1, 32'h22, 4'b0100, 32'h00EE_0000, "merge_byte", 1'b0);
        xact(0, 1'b0, 32'h20, 4'hf, 32'h0, "merge_load", 1'b0);
        total_cnt++;
        if (model0[8] !== 32'hAAEE_CCDD) $display("FAIL merge_model got %h want aaeeccdd", model0[8]);
        else pass_cnt++;
    endtask

    task automatic test_errors();
        xact(0, 1'b1, 32'h21, 4'b0011, 32'hFFFF_FFFF, "err_misalign", 1'b0);
        xact(0, 1'b0, 32'h20, 4'hf, 32'h0, "err_unchanged", 1'b0);
        xact(0, 1'b0, 32'h4000, 4'hf, 32'h0, "err_range", 1'b0);
        xact(0, 1'b0, 32'h24, 4'b0110, 32'h0, "err_be", 1'b0);
    endtask

    task automatic test_busy_ignore();
        xact(0, 1'b1, 32'h50, 4'hf, 32'h1111_2222, "busy_store", 1'b1);
        xact(0, 1'b0, 32'h60, 4'hf, 32'h0, "busy_nowrite", 1'b0);
        xact(0, 1'b0, 32'h50, 4'hf, 32'h0, "busy_orig", 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [3:0] vpat = '0;
        logic [3:0] rpat = '0;
        sb.push_back(predict(1, 1'b1, 32'h40, 4'hf, 32'hCAFE_F00D));
        sb.push_back(predict(1, 1'b0, 32'h40, 4'hf, 32'h0));
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 32'h40, 4'hf, 32'hCAFE_F00D);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            vpat[c-1] = rv(1);
            rpat[c-1] = rdy(1);
            if (rv(1)) check_rsp($sformatf("b2b_rsp_c%0d", c), 1);
            if (c == 1) drive(1, 1'b1, 1'b0, 32'h40, 4'hf, 32'h0);
            if (c == 3) drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        end
        total_cnt++;
        if (vpat !== 4'b0101) $display("FAIL b2b_valid_pattern got %b want 0101", vpat);
        else pass_cnt++;
        total_cnt++;
        if (rpat !== 4'b1010) $display("FAIL b2b_ready_pattern got %b want 1010", rpat);
        else pass_cnt++;
        total_cnt++;
        if (sb.size() != 0) $display("FAIL b2b_pending got %0d want 0", sb.size());
        else pass_cnt++;
        sb.delete();
    endtask

    task automatic test_random();
        logic [3:0] bes [8] = '{4'hf, 4'h3, 4'hc, 4'h1, 4'h2, 4'h4, 4'h8, 4'h6};
        for (int i = 0; i < 12; i++) begin
            logic [31:0] a = 32'h100 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a = a + 32'h4000;
            xact(1, 1'($urandom_range(0, 1)), a, bes[$urandom_range(0, 7)], $urandom,
                 $sformatf("rand%0d", i), 1'b0);
        end
    endtask

    task automatic test_reset_midflight();
        int hits = 0;
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h30, 4'hf, 32'h5A5A_5A5A);
        @(posedge clk);
        #1 drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        rst0 = 1'b0;
        model0.delete();
        #1;
        total_cnt++;
        if ({rdy(0), rv(0), bsy(0)} !== 3'b100)
            $display("FAIL midreset_state got rdy/v/busy %b%b%b want 100", rdy(0), rv(0), bsy(0));
        else pass_cnt++;
        @(negedge clk);
        rst0 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rv(0)) hits++;
        end
        total_cnt++;
        if (hits != 0 || logq.size() != 0)
            $display("FAIL midreset_quiet got rsp %0d log %0d want 0 0", hits, logq.size());
        else pass_cnt++;
        logq.delete();
        xact(0, 1'b0, 32'h30, 4'hf, 32'h0, "midreset_load", 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_word();
        test_byte_merge();
        test_errors();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
